// File: rtl/temp_state_classifier.sv
// Temperature band classifier with debounce and silence timeout.
// Ports: clk, reset (async, active-high), temp[7:0], sample_valid,
//        actual_state[2:0] (0 idle,1 low,2 high,3 danger,4 body),
//        state_chg (1-cycle pulse on change), alarm (state == danger).
module temp_state_classifier #(
    parameter int T_BODY_LO   = 35,
    parameter int T_BODY_HI   = 38,
    parameter int T_DANGER    = 50,
    parameter int CONFIRM     = 3,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] temp,
    input  logic       sample_valid,
    output logic [2:0] actual_state,
    output logic       state_chg,
    output logic       alarm
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOW    = 3'd1,
        S_HIGH   = 3'd2,
        S_DANGER = 3'd3,
        S_BODY   = 3'd4
    } state_t;

    state_t        state_q, state_n;
    state_t        cand_q, cand_n;
    state_t        band;
    logic [3:0]    cnt_q, cnt_n;
    logic [TW-1:0] tcnt_q, tcnt_n;
    logic          chg_q, chg_n;
    logic          alarm_q, alarm_n;
    logic [4:0]    cnt_inc;

    always_comb begin
        band = S_DANGER;
        if (temp < 8'(T_BODY_LO))
            band = S_LOW;
        else if (temp <= 8'(T_BODY_HI))
            band = S_BODY;
        else if (temp < 8'(T_DANGER))
            band = S_HIGH;
    end

    assign cnt_inc = {1'b0, cnt_q} + 5'd1;

    always_comb begin
        state_n = state_q;
        cand_n  = cand_q;
        cnt_n   = cnt_q;
        tcnt_n  = tcnt_q;
        chg_n   = 1'b0;
        if (sample_valid) begin
            // A sample always cancels a pending timeout.
            tcnt_n = '0;
            if (band == state_q) begin
                cnt_n  = '0;
                cand_n = state_q;
            end else if (band == cand_q) begin
                if (cnt_inc == 5'(CONFIRM)) begin
                    state_n = band;
                    cnt_n   = '0;
                    chg_n   = 1'b1;
                end else begin
                    cnt_n = cnt_inc[3:0];
                end
            end else begin
                cand_n = band;
                if (CONFIRM == 1) begin
                    state_n = band;
                    cnt_n   = '0;
                    chg_n   = 1'b1;
                end else begin
                    cnt_n = 4'd1;
                end
            end
        end else if (tcnt_q != TW'(TIMEOUT_CYC)) begin
            // Counter saturates at the threshold, so this fires once.
            tcnt_n = tcnt_q + 1'b1;
            if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                state_n = S_IDLE;
                cand_n  = S_IDLE;
                cnt_n   = '0;
                chg_n   = (state_q != S_IDLE);
            end
        end
        alarm_n = (state_n == S_DANGER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cand_q  <= S_IDLE;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            chg_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_n;
            cand_q  <= cand_n;
            cnt_q   <= cnt_n;
            tcnt_q  <= tcnt_n;
            chg_q   <= chg_n;
            alarm_q <= alarm_n;
        end
    end

    assign actual_state = state_q;
    assign state_chg    = chg_q;
    assign alarm        = alarm_q;

endmodule

// File: tb/tb_temp_state_classifier.sv
// Self-checking bench for temp_state_classifier.
// Scoreboard of expected {state,chg,alarm} against a behavioural model.
module tb_temp_state_classifier;

    localparam int CONF = 3;
    localparam int TO   = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] temp = 8'd0;
    logic       sample_valid = 1'b0;
    logic [2:0] actual_state;
    logic       state_chg;
    logic       alarm;

    int n_chk = 0;
    int n_err = 0;
    int pulses;

    logic [4:0] sb[$];

    // model state
    int m_state, m_run_band, m_run_len, m_idle;

    temp_state_classifier #(
        .T_BODY_LO(35), .T_BODY_HI(38), .T_DANGER(50),
        .CONFIRM(CONF), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .temp(temp),
        .sample_valid(sample_valid),
        .actual_state(actual_state),
        .state_chg(state_chg),
        .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input int t);
        if (t >= 50) return 3;
        if (t > 38) return 2;
        if (t >= 35) return 4;
        return 1;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_run_band = 0;
        m_run_len = 0;
        m_idle = 0;
        sb.delete();
    endtask

    task automatic model_step(input logic v, input int t);
        int b;
        int e_chg;
        e_chg = 0;
        if (v) begin
            m_idle = 0;
            b = classify(t);
            if (b == m_state) begin
                m_run_band = m_state;
                m_run_len = 0;
            end else begin
                if (b == m_run_band) m_run_len++;
                else begin
                    m_run_band = b;
                    m_run_len = 1;
                end
                if (m_run_len >= CONF) begin
                    m_state = b;
                    m_run_len = 0;
                    e_chg = 1;
                end
            end
        end else if (m_idle < TO) begin
            m_idle++;
            if (m_idle == TO) begin
                e_chg = (m_state != 0) ? 1 : 0;
                m_state = 0;
                m_run_band = 0;
                m_run_len = 0;
            end
        end
        sb.push_back({3'(m_state), 1'(e_chg), 1'(m_state == 3)});
    endtask

    task automatic step(input logic v, input int t);
        logic [4:0] e;
        sample_valid = v;
        temp = 8'(t);
        model_step(v, t);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("state", int'(actual_state), int'(e[4:2]));
            chk("chg", int'(state_chg), int'(e[1]));
            chk("alarm", int'(alarm), int'(e[0]));
        end
        sample_valid = 1'b0;
    endtask

    task automatic strobes(input int t, input int n);
        for (int i = 0; i < n; i++) step(1'b1, t);
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        #12;
        chk("rst_state", int'(actual_state), 0);
        chk("rst_chg", int'(state_chg), 0);
        chk("rst_alarm", int'(alarm), 0);
        reset = 1'b0;
        @(negedge clk);

        // idle -> body
        strobes(36, 2);
        chk("body_wait", int'(actual_state), 0);
        step(1'b1, 36);
        chk("body_st", int'(actual_state), 4);
        chk("body_pulse", int'(state_chg), 1);
        step(1'b0, 0);
        chk("body_pulse_end", int'(state_chg), 0);

        // interrupted agreement
        strobes(55, 2);
        step(1'b1, 36);
        strobes(55, 2);
        chk("intr_hold", int'(actual_state), 4);
        step(1'b1, 55);
        chk("danger_st", int'(actual_state), 3);
        chk("danger_alarm", int'(alarm), 1);

        // band boundaries
        strobes(34, 3);  chk("b34", int'(actual_state), 1);
        strobes(35, 3);  chk("b35", int'(actual_state), 4);
        strobes(38, 3);  chk("b38", int'(actual_state), 4);
        strobes(39, 3);  chk("b39", int'(actual_state), 2);
        strobes(49, 3);  chk("b49", int'(actual_state), 2);
        strobes(50, 3);  chk("b50", int'(actual_state), 3);
        strobes(255, 3); chk("b255", int'(actual_state), 3);
        strobes(0, 3);   chk("b0", int'(actual_state), 1);
        strobes(45, 3);  chk("b45", int'(actual_state), 2);

        // timeout, then saturation
        pulses = 0;
        for (int i = 0; i < TO; i++) begin
            step(1'b0, 0);
            if (state_chg) pulses++;
        end
        chk("to_state", int'(actual_state), 0);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 0);
            if (state_chg) pulses++;
        end
        chk("to_pulses", pulses, 1);

        // strobe on the threshold cycle cancels timeout
        strobes(45, 3);
        for (int i = 0; i < TO - 1; i++) step(1'b0, 0);
        step(1'b1, 45);
        chk("to_cancel", int'(actual_state), 2);
        for (int i = 0; i < TO - 1; i++) step(1'b0, 0);
        chk("to_cleared", int'(actual_state), 2);
        step(1'b0, 0);
        chk("to_late", int'(actual_state), 0);

        // async reset mid-debounce
        strobes(36, 3);
        strobes(60, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_state", int'(actual_state), 0);
        chk("arst_alarm", int'(alarm), 0);
        chk("arst_chg", int'(state_chg), 0);
        model_reset();
        #1;
        reset = 1'b0;
        strobes(60, 2);
        chk("arst_lost", int'(actual_state), 0);
        step(1'b1, 60);
        chk("arst_commit", int'(actual_state), 3);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 6)
                step(1'b1, int'($urandom_range(30, 56)));
            else
                step(1'b0, 0);
        end
        for (int i = 0; i < TO + 2; i++) step(1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
